// File: rtl/slave_mem_sequencer.sv
// Sequencer: loads a byte stream into a slave RAM, pulses a DUT start, then streams the RAM back out.
// Latency: one slave access per byte, each followed by a wait for DataRdy; RUN bounded by TIMEOUT cycles.
// Backpressure: in_ready only in WR_REQ; out_valid/out_data held stable in OUT until out_ready.
module slave_mem_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       len,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [7:0]            out_data,
  input  logic                  out_ready,
  output logic                  start_port,
  input  logic                  done_port,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [13:0]           S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  busy,
  output logic                  seq_done,
  output logic                  timeout
);

  typedef enum logic [3:0] {
    IDLE, WR_REQ, WR_WAIT, START, RUN, RD_REQ, RD_WAIT, OUT, FIN
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   idx;
  logic [ADDR_W:0]   idx_inc;
  logic              idx_last;
  logic [31:0]       run_cnt;
  logic [31:0]       run_nxt;
  logic              run_expire;
  logic [ADDR_W-1:0] slv_addr;
  logic              slv_rdy;
  logic [7:0]        slv_dat;
  logic              wr_fire;
  logic              we0;
  logic              oe0;
  logic              access;
  // A DataRdy seen in the request cycle itself is remembered so the wait state still sees it.
  logic              early_vld;
  logic [7:0]        early_dat;
  // Channel 1 and the upper read-data bits are never consumed.
  logic              unused_bits;

  assign unused_bits = ^{Sout_Rdata_ram[2*DATA_W-1:8], Sout_DataRdy[1]};

  assign idx_inc    = idx + (ADDR_W+1)'(1);
  assign idx_last   = (idx_inc == len_q);
  assign slv_addr   = base_q + idx[ADDR_W-1:0];
  assign slv_rdy    = Sout_DataRdy[0] | early_vld;
  assign slv_dat    = early_vld ? early_dat : Sout_Rdata_ram[7:0];
  assign run_nxt    = run_cnt + 32'd1;
  assign run_expire = (run_nxt == 32'(TIMEOUT));
  assign wr_fire    = (state == WR_REQ) && in_valid;
  assign access     = we0 | oe0;

  // Only channel 0 is ever driven; every slave field is zero outside a request cycle.
  assign S_we_ram        = {1'b0, we0};
  assign S_oe_ram        = {1'b0, oe0};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, (access ? slv_addr : {ADDR_W{1'b0}})};
  assign S_Wdata_ram     = {{DATA_W{1'b0}}, {(DATA_W-8){1'b0}}, (we0 ? in_data : 8'h00)};
  assign S_data_ram_size = {7'd0, (access ? 7'd8 : 7'd0)};

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and per-state strobes.
  always_comb begin
    state_nxt  = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    start_port = 1'b0;
    seq_done   = 1'b0;
    we0        = 1'b0;
    oe0        = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE:    if (go) state_nxt = (len == '0) ? START : WR_REQ;
      WR_REQ: begin
        in_ready = 1'b1;
        if (in_valid) begin
          we0       = 1'b1;
          state_nxt = WR_WAIT;
        end
      end
      WR_WAIT: if (slv_rdy) state_nxt = idx_last ? START : WR_REQ;
      START: begin
        start_port = 1'b1;
        state_nxt  = RUN;
      end
      RUN: begin
        if (done_port)       state_nxt = (len_q == '0) ? FIN : RD_REQ;
        else if (run_expire) state_nxt = FIN;
      end
      RD_REQ: begin
        oe0       = 1'b1;
        state_nxt = RD_WAIT;
      end
      RD_WAIT: if (slv_rdy) state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = idx_last ? FIN : RD_REQ;
      end
      FIN: begin
        seq_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Sequence context: latched parameters, byte index, RUN counter, readback byte and status.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      base_q    <= '0;
      len_q     <= '0;
      idx       <= '0;
      run_cnt   <= '0;
      out_data  <= '0;
      timeout   <= 1'b0;
      early_vld <= 1'b0;
      early_dat <= '0;
    end else begin
      early_vld <= (wr_fire || (state == RD_REQ)) && Sout_DataRdy[0];
      early_dat <= Sout_Rdata_ram[7:0];
      case (state)
        IDLE: begin
          if (go) begin
            base_q  <= base_addr;
            len_q   <= len;
            idx     <= '0;
            timeout <= 1'b0;
          end
        end
        WR_WAIT: if (slv_rdy) idx <= idx_inc;
        START:   run_cnt <= '0;
        RUN: begin
          run_cnt <= run_nxt;
          if (done_port)       idx     <= '0;
          else if (run_expire) timeout <= 1'b1;
        end
        RD_WAIT: if (slv_rdy) out_data <= slv_dat;
        OUT:     if (out_ready) idx <= idx_inc;
        default: ;
      endcase
    end
  end

endmodule
